// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: converts a signed 8-bit value to sign + three BCD digits
// and scans them onto a 4-digit common-anode 7-segment display.
// Optional feature macro: LEAD_ZERO_BLANK_EN (blank leading zeros in the
// hundreds and tens positions; the minus sign is unaffected).
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for load; display shows the last latched value
// S_CONVERT | 8 shift-add-3 steps turning the magnitude into BCD
// S_LATCH   | copy sign and BCD digits into the display registers
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] value,
    output logic       busy,
    output logic       done,
    output logic [6:0] SEG,
    output logic [3:0] AN
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_LATCH} state_t;

    state_t           state, state_next;
    logic [2:0]       step;
    logic [7:0]       bin;
    logic [11:0]      bcd;
    logic             sign_r;
    logic             done_r;
    logic [7:0]       mag;
    logic [3:0]       units_adj, tens_adj;
    logic             disp_sign;
    logic [3:0]       disp_h, disp_t, disp_u;
    logic [PRE_W-1:0] pre;
    logic [1:0]       scan_idx;
    logic [3:0]       show_h, show_t;

    // -128 negates to 8'h80, which read as unsigned is the wanted 128
    assign mag       = value[7] ? (~value + 8'd1) : value;
    // hundreds never exceeds 2 for an 8-bit input, so it never needs the +3
    assign units_adj = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    assign tens_adj  = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];

    assign busy = (state != S_IDLE);
    assign done = done_r;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (load) state_next = S_CONVERT;
            S_CONVERT: if (step == 3'd7) state_next = S_LATCH;
            S_LATCH:   state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // conversion datapath and display registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step      <= '0;
            bin       <= '0;
            bcd       <= '0;
            sign_r    <= 1'b0;
            done_r    <= 1'b0;
            disp_sign <= 1'b0;
            disp_h    <= '0;
            disp_t    <= '0;
            disp_u    <= '0;
        end else begin
            done_r <= (state == S_LATCH);
            if (state == S_IDLE && load) begin
                sign_r <= value[7];
                bin    <= mag;
                bcd    <= '0;
                step   <= '0;
            end else if (state == S_CONVERT) begin
                bcd  <= {bcd[10:8], tens_adj, units_adj, bin[7]};
                bin  <= {bin[6:0], 1'b0};
                step <= step + 3'd1;
            end
            if (state == S_LATCH) begin
                disp_sign <= sign_r;
                disp_h    <= bcd[11:8];
                disp_t    <= bcd[7:4];
                disp_u    <= bcd[3:0];
            end
        end
    end

    // free-running refresh prescaler and digit scan index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre      <= '0;
            scan_idx <= '0;
        end else if (pre == PRE_LAST) begin
            pre      <= '0;
            scan_idx <= scan_idx + 2'd1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0011000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    // leading-zero handling: a blanked digit is replaced by a non-decimal nibble
`ifdef LEAD_ZERO_BLANK_EN
    always_comb begin
        show_h = (disp_h == 4'd0) ? 4'hF : disp_h;
        show_t = (disp_h == 4'd0 && disp_t == 4'd0) ? 4'hF : disp_t;
    end
`else
    always_comb begin
        show_h = disp_h;
        show_t = disp_t;
    end
`endif

    // digit select and segment mux
    always_comb begin
        AN  = ~(4'b0001 << scan_idx);
        SEG = 7'b1111111;
        case (scan_idx)
            2'd0:    SEG = seg_code(disp_u);
            2'd1:    SEG = seg_code(show_t);
            2'd2:    SEG = seg_code(show_h);
            2'd3:    SEG = disp_sign ? 7'b0111111 : 7'b1111111;
            default: SEG = 7'b1111111;
        endcase
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit position is driven before the scan advances (legal range 2..2^20).
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port load, input, 1, one-cycle strobe requesting display of value.
REQ-005 SHALL have port value, input, 8, signed two's-complement number to display (-128..127).
REQ-006 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-007 SHALL have port done, output, 1, one-cycle pulse when new digits become visible.
REQ-008 SHALL have port SEG, output, 7, active-low segments gfedcba for the selected digit.
REQ-009 SHALL have port AN, output, 4, active-low one-hot digit select; AN[0] = units (rightmost), AN[3] = sign position.

Function
REQ-010 SHALL implement FSM IDLE -> CONVERT -> LATCH -> IDLE.
REQ-011 IDLE: load=1 at edge t captures sign = value[7] and magnitude = |value| (9-bit-safe; -128 gives 128), enters CONVERT.
REQ-012 CONVERT SHALL run iterative shift-add-3 binary-to-BCD for exactly 8 cycles (edges t+1..t+8), producing hundreds/tens/units nibbles.
REQ-013 LATCH SHALL copy sign and the three BCD nibbles into display registers at edge t+9 and return to IDLE.
REQ-014 busy SHALL be 1 in the 9 cycles following edges t..t+8, otherwise 0.
REQ-015 done SHALL be 1 only in the cycle following edge t+9; a load in that cycle is accepted.
REQ-016 load while busy=1 SHALL be ignored (no queueing, no corruption of conversion in flight).
REQ-017 Display registers SHALL change only in LATCH; old digits stay displayed throughout CONVERT.
REQ-018 Prescaler SHALL count 0..REFRESH_DIV-1 continuously, independent of FSM; on wrap, scan index increments 0->1->2->3->0.
REQ-019 AN SHALL assert low only the bit equal to scan index; SEG/AN are combinational from registered state (no added latency).
REQ-020 Index 0/1/2 SHALL show units/tens/hundreds digits with codes 0..9 = 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0011000.
REQ-021 Index 3 SHALL show minus 0111111 when sign=1, blank 1111111 when sign=0.
REQ-022 Units digit SHALL never be blanked; value 0 shows "0" with sign blank.
REQ-023 Any BCD nibble > 9 (unreachable) SHALL decode to blank 1111111.

Reset
REQ-024 reset=1 SHALL immediately force IDLE, busy=0, done=0, prescaler=0, scan index=0, sign=0, all digit registers 0, abandoning any conversion.
REQ-025 During and after reset until first tick: AN=1110, SEG=1000000 ("0" in units).
REQ-026 Deassertion SHALL need no synchronous settle cycle; load at first post-reset edge is accepted.

Configuration
REQ-027 Macro LEAD_ZERO_BLANK_EN defined: hundreds blanked when 0; tens blanked when hundreds=0 and tens=0; minus unaffected.
REQ-028 Macro LEAD_ZERO_BLANK_EN undefined: hundreds and tens always shown, leading zeros displayed as 1000000.

Verification (REFRESH_DIV=4)
REQ-029 load value=8'd37 -> busy 9 cycles, done pulse at t+10 cycle; scan shows 1111111, hundreds(0), 0110000, 1111000 per index 3..0.
REQ-030 load value=8'h80 (-128) -> index3 0111111, index2 1111001, index1 0100100, index0 0000000.
REQ-031 load 5 then load 99 two cycles later -> second ignored; done once; display shows 5.
REQ-032 reset asserted at CONVERT cycle 4 of value 123 -> busy=0 immediately, display "0", AN=1110; no done.
REQ-033 value=8'd7 with/without LEAD_ZERO_BLANK_EN -> hundreds/tens 1111111 vs 1000000; units 1111000 both.
REQ-034 free run 16 cycles -> AN sequence 1110,1101,1011,0111 each held 4 cycles, then wraps to 1110.
